// File: rtl/serial_align_ctrl.sv
// Byte-alignment and link-sync controller for the PHY receive path (clk_32f domain).
// Hunts for the comma symbol, verifies a run of aligned commas, then strobes aligned bytes.
module serial_align_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 64
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       hunt_req,
    output logic [7:0] byte_out,
    output logic       byte_stb,
    output logic       valid_out,
    output logic       active,
    output logic       lock_lost,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [7:0] GAP_LIMIT   = 8'(MAX_GAP);

    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_ph;
    logic [3:0] r_comma_cnt;
    logic [7:0] r_gap_cnt;
    logic [7:0] r_byte;
    logic       r_stb;
    logic       r_valid;
    logic       r_active;
    logic       r_lost;

    state_t     w_state;
    logic [2:0] w_ph;
    logic [3:0] w_comma_cnt;
    logic [7:0] w_gap_cnt;
    logic [7:0] w_byte;
    logic       w_stb;
    logic       w_valid;
    logic       w_lost;
    logic       w_is_comma;
    logic       w_boundary;

    assign w_is_comma = (r_sr == COMMA);
    assign w_boundary = (r_ph == 3'd0);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        w_state     = r_state;
        w_ph        = r_ph + 3'd1;
        w_comma_cnt = r_comma_cnt;
        w_gap_cnt   = r_gap_cnt;
        w_byte      = r_byte;
        w_stb       = 1'b0;
        w_valid     = 1'b0;
        w_lost      = 1'b0;

        if (hunt_req) begin
            w_state     = ST_HUNT;
            w_comma_cnt = 4'd0;
            w_gap_cnt   = 8'd0;
            w_lost      = (r_state == ST_LOCKED);
        end else begin
            unique case (r_state)
                ST_HUNT: begin
                    // Any bit position may hold the comma; a hit re-phases the byte counter.
                    if (w_is_comma) begin
                        w_ph        = 3'd1;
                        w_comma_cnt = 4'd1;
                        w_gap_cnt   = 8'd0;
                        w_state     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            w_comma_cnt = r_comma_cnt + 4'd1;
                            if (r_comma_cnt + 4'd1 == LOCK_TARGET) begin
                                w_state   = ST_LOCKED;
                                w_gap_cnt = 8'd0;
                            end
                        end else begin
                            w_state     = ST_HUNT;
                            w_comma_cnt = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_boundary) begin
                        w_byte  = r_sr;
                        w_stb   = 1'b1;
                        w_valid = !w_is_comma;
                        if (w_is_comma) begin
                            w_gap_cnt = 8'd0;
                        end else begin
                            w_gap_cnt = r_gap_cnt + 8'd1;
                            // The byte that exhausts the gap budget is still delivered.
                            if (r_gap_cnt + 8'd1 == GAP_LIMIT) begin
                                w_state     = ST_HUNT;
                                w_lost      = 1'b1;
                                w_comma_cnt = 4'd0;
                            end
                        end
                    end
                end
                default: begin
                    w_state = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_32f) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state     <= ST_HUNT;
            r_sr        <= 8'd0;
            r_ph        <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_gap_cnt   <= 8'd0;
            r_byte      <= 8'd0;
            r_stb       <= 1'b0;
            r_valid     <= 1'b0;
            r_active    <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sr        <= {r_sr[6:0], data_in};
            r_ph        <= w_ph;
            r_comma_cnt <= w_comma_cnt;
            r_gap_cnt   <= w_gap_cnt;
            r_byte      <= w_byte;
            r_stb       <= w_stb;
            r_valid     <= w_valid;
            r_active    <= (w_state == ST_LOCKED);
            r_lost      <= w_lost;
        end
    end

    assign byte_out  = r_byte;
    assign byte_stb  = r_stb;
    assign valid_out = r_valid;
    assign active    = r_active;
    assign lock_lost = r_lost;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_serial_align_ctrl.sv
// Scoreboard bench for serial_align_ctrl: stimulus queues expected strobes, a
// negedge monitor pops and compares them.
module tb_serial_align_ctrl;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic       hunt_req;
    logic [7:0] byte_out;
    logic       byte_stb;
    logic       valid_out;
    logic       active;
    logic       lock_lost;
    logic [1:0] state_dbg;

    typedef struct packed {
        logic [7:0] b;
        logic       v;
        logic       l;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   lost_cnt = 0;

    serial_align_ctrl dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .hunt_req (hunt_req),
        .byte_out (byte_out),
        .byte_stb (byte_stb),
        .valid_out(valid_out),
        .active   (active),
        .lock_lost(lock_lost),
        .state_dbg(state_dbg)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk_32f) begin
        exp_t e;
        if (byte_stb) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL stray_stb: got strobe of %0h, required no strobe", byte_out);
            end else begin
                e = sb_q.pop_front();
                check("stb_byte", {24'd0, byte_out}, {24'd0, e.b});
                check("stb_valid", {31'd0, valid_out}, {31'd0, e.v});
                check("stb_lost", {31'd0, lock_lost}, {31'd0, e.l});
            end
        end else if (valid_out) begin
            total_cnt++;
            $display("FAIL stray_valid: got valid_out=1, required 0 without strobe");
        end
        if (lock_lost) lost_cnt++;
    end

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic push_send(input logic [7:0] b, input logic v, input logic l);
        exp_t e;
        e.b = b;
        e.v = v;
        e.l = l;
        sb_q.push_back(e);
        send_byte(b);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    // Pad, then four aligned commas; returns in the 4th comma's boundary cycle.
    task automatic lock_link(input int n);
        pad(n);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        check("lock_pre_state", {30'd0, state_dbg}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        reset    = 1'b1;
        data_in  = 1'b0;
        hunt_req = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_outs", {20'd0, byte_out, byte_stb, valid_out, active, lock_lost}, 32'd0);
        reset = 1'b0;

        // Lock at bit offset 3, then first data byte.
        pad(3);
        send_byte(COMMA);
        check("t1_hunt_match", {30'd0, state_dbg}, 32'd0);
        send_byte(COMMA);
        check("t1_verify", {30'd0, state_dbg}, 32'd1);
        send_byte(COMMA);
        send_byte(COMMA);
        check("t1_pre_lock_state", {30'd0, state_dbg}, 32'd1);
        check("t1_pre_lock_active", {31'd0, active}, 32'd0);
        send_bit(1'b1);
        check("t1_locked", {30'd0, state_dbg}, 32'd2);
        check("t1_active", {31'd0, active}, 32'd1);
        for (int i = 6; i >= 0; i--) send_bit(d_a5(i));
        begin
            exp_t e;
            e.b = 8'hA5; e.v = 1'b1; e.l = 1'b0;
            sb_q.push_back(e);
        end

        // Periodic comma keeps the link up.
        push_send(COMMA, 1'b0, 1'b0);
        push_send(8'h11, 1'b1, 1'b0);
        push_send(8'h22, 1'b1, 1'b0);
        for (int r = 0; r < 50; r++) begin
            push_send(COMMA, 1'b0, 1'b0);
            for (int k = 1; k < 10; k++) begin
                d = 8'((r * 10 + k) & 8'h7F);
                push_send(d, 1'b1, 1'b0);
            end
        end
        check("t3_active", {31'd0, active}, 32'd1);
        check("t3_no_loss", lost_cnt, 32'd0);

        // hunt_req mid-byte.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        hunt_req = 1'b1;
        send_bit(1'b1);
        hunt_req = 1'b0;
        check("t5_state", {30'd0, state_dbg}, 32'd0);
        check("t5_lost", {31'd0, lock_lost}, 32'd1);
        check("t5_active", {31'd0, active}, 32'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        lock_link(5);
        push_send(8'h5A, 1'b1, 1'b0);
        check("t5_relock", {30'd0, state_dbg}, 32'd2);
        push_send(COMMA, 1'b0, 1'b0);

        // Comma starvation: the 64th data byte drops lock.
        for (int i = 0; i < 64; i++) push_send(8'(i), 1'b1, (i == 63));
        pad(8);
        check("t2_state", {30'd0, state_dbg}, 32'd0);
        check("t2_active", {31'd0, active}, 32'd0);
        check("t2_lost_cnt", lost_cnt, 32'd2);

        // Broken verify run.
        send_byte(COMMA);
        send_byte(COMMA);
        check("t4_verify", {30'd0, state_dbg}, 32'd1);
        check("t4_active_a", {31'd0, active}, 32'd0);
        send_byte(8'h3C);
        pad(8);
        check("t4_back_hunt", {30'd0, state_dbg}, 32'd0);
        check("t4_active_b", {31'd0, active}, 32'd0);

        // Reset at ph == 4 while locked.
        lock_link(4);
        push_send(8'h77, 1'b1, 1'b0);
        pad(4);
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        check("t6_state", {30'd0, state_dbg}, 32'd0);
        check("t6_outs", {20'd0, byte_out, byte_stb, valid_out, active, lock_lost}, 32'd0);
        pad(3);
        send_byte(COMMA);
        send_bit(1'b0);
        check("t6_reacquire", {30'd0, state_dbg}, 32'd1);
        pad(4);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    function automatic logic d_a5(input int i);
        logic [7:0] v;
        v = 8'hA5;
        return v[i];
    endfunction

endmodule
